// File: rtl/inst_fetch_pkg.sv
// Shared CPU package: fetch FSM state encoding, reset vector and address helpers.
package inst_fetch_pkg;

    // Address the PC register holds straight out of reset.
    localparam logic [31:0] RESET_PC = 32'hbfc00000;

    // Fetch FSM states; at most one SRAM request is ever outstanding.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,  // waiting for a fetchable PC and a free output buffer
        S_REQ  = 2'd1,  // request driven, waiting for the address handshake
        S_WAIT = 2'd2,  // address accepted, waiting for the returned word
        S_DROP = 2'd3   // flushed while waiting; swallow the returned word
    } fetch_state_e;

    // Word fetches require the two low address bits to be zero.
    function automatic logic addr_misaligned(input logic [1:0] addr_lsb);
        return (addr_lsb != 2'b00);
    endfunction

endpackage : inst_fetch_pkg

// File: rtl/inst_fetch_if.sv
// Instruction-SRAM request/response bus between the fetch stage and the SRAM.
interface inst_fetch_if #(
    parameter int WIDTH = 32
);
    logic             inst_req_o;
    logic [WIDTH-1:0] inst_addr_o;
    logic             inst_addr_ok_i;
    logic             inst_data_ok_i;
    logic [WIDTH-1:0] inst_rdata_i;

    // Fetch stage side: issues requests, receives handshakes and data.
    modport master (
        output inst_req_o,
        output inst_addr_o,
        input  inst_addr_ok_i,
        input  inst_data_ok_i,
        input  inst_rdata_i
    );

    // SRAM side: accepts requests, returns handshakes and data.
    modport slave (
        input  inst_req_o,
        input  inst_addr_o,
        output inst_addr_ok_i,
        output inst_data_ok_i,
        output inst_rdata_i
    );
endinterface : inst_fetch_if

// File: rtl/inst_fetch.sv
// Instruction fetch stage: drives one SRAM request at a time, buffers the
// returned word in a one-entry buffer toward decode, raises an address-error
// entry for a misaligned PC and discards in-flight data after a flush.
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] pc_i,
    output logic             pc_en_o,
    input  logic             flush_i,
    inst_fetch_if.master     sram,
    output logic [WIDTH-1:0] inst_o,
    output logic [WIDTH-1:0] inst_pc_o,
    output logic             inst_valid_o,
    output logic             exc_adel_o,
    input  logic             id_ready_i
);

    fetch_state_e     r_state;
    fetch_state_e     w_next_state;
    logic [WIDTH-1:0] r_addr;
    logic [WIDTH-1:0] r_inst;
    logic [WIDTH-1:0] r_pc;
    logic             r_valid;
    logic             r_adel;
    logic             r_exc_pending;

    logic             w_req;
    logic             w_addr_hs;
    logic             w_consume;
    logic             w_buf_free;
    logic             w_fetch_start;
    logic             w_exc_load;
    logic             w_data_load;

    // A flush withdraws the request in the same cycle so the PC register
    // never advances past an address that is being thrown away.
    assign w_req      = (r_state == S_REQ) & ~flush_i;
    assign w_addr_hs  = w_req & sram.inst_addr_ok_i;
    assign w_consume  = r_valid & id_ready_i;
    assign w_buf_free = ~r_valid | w_consume;

    assign sram.inst_req_o  = w_req;
    assign sram.inst_addr_o = r_addr;
    assign pc_en_o          = w_addr_hs;

    assign inst_o       = r_inst;
    assign inst_pc_o    = r_pc;
    assign inst_valid_o = r_valid;
    assign exc_adel_o   = r_adel;

    // FSM next-state and the buffer-load strobes derived from it.
    always_comb begin
        w_next_state  = r_state;
        w_fetch_start = 1'b0;
        w_exc_load    = 1'b0;
        w_data_load   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!flush_i && !r_exc_pending && w_buf_free) begin
                    if (!addr_misaligned(pc_i[1:0])) begin
                        w_next_state  = S_REQ;
                        w_fetch_start = 1'b1;
                    end else begin
                        // No SRAM access: the error entry goes straight to decode.
                        w_next_state = S_IDLE;
                        w_exc_load   = 1'b1;
                    end
                end else begin
                    w_next_state = S_IDLE;
                end
            end
            S_REQ: begin
                if (flush_i) begin
                    w_next_state = S_IDLE;
                end else if (w_addr_hs) begin
                    w_next_state = S_WAIT;
                end else begin
                    w_next_state = S_REQ;
                end
            end
            S_WAIT: begin
                if (flush_i) begin
                    // Data arriving with the flush completes the access; otherwise
                    // the response is still owed and must be swallowed later.
                    if (sram.inst_data_ok_i) begin
                        w_next_state = S_IDLE;
                    end else begin
                        w_next_state = S_DROP;
                    end
                end else if (sram.inst_data_ok_i) begin
                    w_next_state = S_IDLE;
                    w_data_load  = 1'b1;
                end else begin
                    w_next_state = S_WAIT;
                end
            end
            S_DROP: begin
                if (sram.inst_data_ok_i) begin
                    w_next_state = S_IDLE;
                end else begin
                    w_next_state = S_DROP;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Request address, captured from the PC register when a fetch starts.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_addr <= {WIDTH{1'b0}};
        end else if (w_fetch_start) begin
            r_addr <= pc_i;
        end else begin
            r_addr <= r_addr;
        end
    end

    // One-entry output buffer toward decode; flush beats any load.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_valid <= 1'b0;
            r_adel  <= 1'b0;
            r_inst  <= {WIDTH{1'b0}};
            r_pc    <= {WIDTH{1'b0}};
        end else if (flush_i) begin
            r_valid <= 1'b0;
            r_adel  <= 1'b0;
        end else if (w_data_load) begin
            r_valid <= 1'b1;
            r_adel  <= 1'b0;
            r_inst  <= sram.inst_rdata_i;
            r_pc    <= r_addr;
        end else if (w_exc_load) begin
            r_valid <= 1'b1;
            r_adel  <= 1'b1;
            r_inst  <= {WIDTH{1'b0}};
            r_pc    <= pc_i;
        end else if (w_consume) begin
            r_valid <= 1'b0;
            r_adel  <= 1'b0;
        end else begin
            r_valid <= r_valid;
            r_adel  <= r_adel;
        end
    end

    // Address-error latch: stops fetching until the exception flush arrives.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_exc_pending <= 1'b0;
        end else if (flush_i) begin
            r_exc_pending <= 1'b0;
        end else if (w_exc_load) begin
            r_exc_pending <= 1'b1;
        end else begin
            r_exc_pending <= r_exc_pending;
        end
    end

endmodule : inst_fetch

// File: doc/inst_fetch.md
INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 SHALL have parameter WIDTH, default 32, the address and instruction width.
REQ-002 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1: asynchronous, active-low reset.
REQ-004 SHALL have port pc_i, input, WIDTH: current PC, taken from the PC register output.
REQ-005 SHALL have port pc_en_o, output, 1: advance enable to the PC register, meaning this address was accepted.
REQ-006 SHALL have port flush_i, input, 1: exception/redirect flush; the PC register loads its new PC in the same cycle.
REQ-007 SHALL have ports inst_req_o (output, 1) and inst_addr_o (output, WIDTH), the instruction-SRAM request.
REQ-008 SHALL have ports inst_addr_ok_i (input, 1), inst_data_ok_i (input, 1) and inst_rdata_i (input, WIDTH), the SRAM handshake.
REQ-009 SHALL have ports inst_o (output, WIDTH), inst_pc_o (output, WIDTH), inst_valid_o (output, 1) and exc_adel_o (output, 1), toward decode.
REQ-010 SHALL have port id_ready_i, input, 1: decode accepts the entry when inst_valid_o & id_ready_i.

Function
REQ-011 SHALL implement FSM states IDLE, REQ, WAIT, DROP, with at most one outstanding SRAM request.
REQ-012 inst_req_o SHALL equal (state==REQ) & ~flush_i, and inst_addr_o SHALL equal the PC latched on entering REQ.
REQ-013 IDLE->REQ SHALL occur when pc_i[1:0]==0, flush_i==0, no exception is pending, and the output buffer is empty or is being consumed this cycle.
REQ-014 REQ->WAIT SHALL occur on inst_req_o & inst_addr_ok_i, and REQ->IDLE on flush_i.
REQ-015 pc_en_o SHALL equal inst_req_o & inst_addr_ok_i, combinational, and is therefore 0 whenever flush_i=1.
REQ-016 WAIT->IDLE SHALL occur on inst_data_ok_i: the one-entry output buffer loads inst_rdata_i and the request PC, and inst_valid_o=1 from the next cycle (minimum latency: addr handshake n, data n+1, valid n+2).
REQ-017 WAIT with flush_i=1 SHALL go to DROP (or straight to IDLE, discarding the data, if inst_data_ok_i=1 in the same cycle).
REQ-018 DROP->IDLE SHALL occur on inst_data_ok_i, and the returned data SHALL be discarded.
REQ-019 The output buffer SHALL hold inst_o, inst_pc_o and exc_adel_o stable while inst_valid_o & ~id_ready_i.
REQ-020 The output buffer SHALL clear on consume unless it is reloaded in the same cycle.
REQ-021 In IDLE with pc_i[1:0]!=0 and the buffer free: no request and no pc_en_o; the buffer loads inst_o=0, inst_pc_o=pc_i, exc_adel_o=1; exc_pending is set.
REQ-022 exc_pending SHALL block further fetches and SHALL clear only on flush_i.
REQ-023 flush_i SHALL clear inst_valid_o and exc_pending on the next edge and SHALL take priority over a simultaneous buffer load.
REQ-024 inst_addr_ok_i or inst_data_ok_i arriving in an unexpected state SHALL be ignored.

Reset
REQ-025 While rst=0, asynchronously: state=IDLE; inst_valid_o=0; exc_adel_o=0; exc_pending=0; inst_o=0; inst_pc_o=0; latched address=0.
REQ-026 The first request after reset release SHALL carry the PC register's reset address 32'hbfc00000.
REQ-027 A reset asserted mid-transaction SHALL abandon the transaction, and a late inst_data_ok_i after release SHALL be ignored per REQ-024.

Structure
REQ-028 The FSM state encoding and the reset vector constant 32'hbfc00000 SHALL live in the shared CPU package.
REQ-029 The block SHALL be flat, with no sub-modules; the output buffer and FSM are in one module.

Verification
REQ-030 The bench SHALL cover: reset release with pc_i=32'hbfc00000, addr_ok=1 immediately, data_ok next cycle with 32'h3c08bfc0 -> req on cycle 1, pc_en_o one cycle, inst_valid_o with inst_pc_o=32'hbfc00000 two cycles later.
REQ-031 The bench SHALL cover: id_ready_i=0 for 3 cycles with a valid entry -> outputs stable, no new request, pc_en_o=0; after release, back-to-back fetch resumes.
REQ-032 The bench SHALL cover: flush_i in WAIT, data_ok 2 cycles later -> DROP, data discarded, inst_valid_o stays 0, next request uses the new pc_i.
REQ-033 The bench SHALL cover: pc_i=32'hbfc00002 -> no inst_req_o, inst_valid_o=1, exc_adel_o=1, inst_pc_o=32'hbfc00002, no refetch until flush_i.
REQ-034 The bench SHALL cover: flush_i in REQ with addr_ok=1 in the same cycle -> inst_req_o=0, pc_en_o=0, state IDLE.
REQ-035 The bench SHALL cover: rst low while in WAIT, then a stray data_ok after release -> all outputs 0, stray data ignored.
